residual_add_scheduler: RTL
===========================

# residual_add_scheduler

Sequencer that time-multiplexes one internal `adder_768` across up to ADDER_NUM rows of a residual (skip-connection) add. It sits between two row-addressed source buffers (layer output and residual) and one destination buffer. Each row is read, summed element-wise over DIMENTION lanes and written back, so one row adder replaces ADDER_NUM parallel instances. Firmware/top-level control starts it with a pulse and waits for `done`.

## Interface
- ADDER_NUM, 128, maximum rows per job (tokens)
- DIMENTION, 768, elements per row
- WIDTH_ADDEND, 32, element width (signed)
- WIDTH_SUM, WIDTH_ADDEND, sum element width
- ROW_AW, $clog2(ADDER_NUM), row address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job start pulse, sampled only in IDLE
- abort  in  1  synchronous job cancel
- row_count  in  ROW_AW+1  rows in job, sampled with start
- busy  out  1  high from cycle after accepted start until DONE
- done  out  1  one-cycle completion pulse
- rd_en  out  1  source read strobe (both buffers)
- rd_addr  out  ROW_AW  source row index
- rd_data1  in  WIDTH_ADDEND*DIMENTION  addend1 row, valid the cycle after rd_en
- rd_data2  in  WIDTH_ADDEND*DIMENTION  addend2 row, valid the cycle after rd_en
- wr_en  out  1  destination write request
- wr_addr  out  ROW_AW  destination row index
- wr_data  out  WIDTH_SUM*DIMENTION  sum row
- wr_ready  in  1  destination accepts write when wr_en && wr_ready

## Operation
- States: IDLE, READ, LATCH, WRITE, DONE.
- IDLE: start=1 → latch N = min(row_count, ADDER_NUM), clear row counter r=0; N=0 → DONE, else → READ. start in any other state ignored.
- READ (1 cycle): rd_en=1, rd_addr=r → LATCH.
- LATCH (1 cycle): adder output of rd_data1/rd_data2 registered into wr_data → WRITE.
- WRITE: wr_en=1, wr_addr=r, wr_data held stable until wr_ready. On accept: r==N-1 → DONE, else r=r+1 → READ.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- abort=1 in READ/LATCH/WRITE → IDLE next cycle, no done, wr_en dropped immediately next cycle (write in abort cycle counts only if wr_ready was also 1). abort has priority over all transitions; abort in IDLE/DONE has no effect.
- Arithmetic: lane k (bits k*W+W-1:k*W) sum = addend1 lane + addend2 lane, two's complement, wraps modulo 2^WIDTH_SUM; no saturation, no carry between lanes.
- rd_addr/wr_addr hold last value when idle.

## Timing
- Reset: state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data, row counter = 0.
- Start sampled in cycle 0; READ for row 0 in cycle 1; wr_en first high cycle 3.
- Per row minimum 3 cycles (wr_ready held 1); each wr_ready-low cycle in WRITE adds one.
- N rows, wr_ready always 1: done high in cycle 3N+1; busy high cycles 1..3N.
- N=0: done high in cycle 1, no rd_en/wr_en.
- start and abort same cycle in IDLE: start accepted.
- start coincident with done (DONE state): ignored; new start accepted from next cycle.
- rst mid-job: all outputs to reset values next cycle, no done.

## Test plan
- Reset: hold rst 2 cycles mid-WRITE → next cycle busy=0, wr_en=0, wr_data=0, state IDLE.
- Single row, N=1, rd_data1 lanes = k, rd_data2 lanes = 2k, wr_ready=1 → wr_en cycle 3, wr_addr=0, lane k = 3k, done cycle 4.
- Full job N=128, random signed data, wr_ready=1 → 128 writes, addresses 0..127 in order, done cycle 385, every lane matches model.
- Wrap/sign: lane 0x7FFFFFFF + 0x00000001 → 0x80000000; 0xFFFFFFFF + 0xFFFFFFFF → 0xFFFFFFFE; neighbouring lanes unaffected.
- Backpressure: N=4, wr_ready low 5 cycles on row 2 → wr_data/wr_addr stable while stalled, done at cycle 13+5=18.
- Edge cases: row_count=0 → done cycle 1 no accesses; row_count=200 → clamped to 128 writes; abort in LATCH of row 3 → IDLE next cycle, no done, no further writes, new start then runs normally.

Source files
------------

// File: rtl/residual_add_scheduler.sv
// Residual add sequencer: one shared row adder walks rows 0..N-1,
// reading both source buffers, summing lane-wise and writing the result.

// One lane of the row adder: two's-complement add, wraps at WS bits.
module residual_add_lane #(
  parameter int WA = 32,
  parameter int WS = WA
) (
  input  logic [WA-1:0] a,
  input  logic [WA-1:0] b,
  output logic [WS-1:0] s
);
  assign s = WS'($signed(a)) + WS'($signed(b));
endmodule

// Full-row adder: DIMENTION independent lanes, no carry between lanes.
module adder_768 #(
  parameter int DIMENTION = 768,
  parameter int WA        = 32,
  parameter int WS        = WA
) (
  input  logic [WA*DIMENTION-1:0] a,
  input  logic [WA*DIMENTION-1:0] b,
  output logic [WS*DIMENTION-1:0] s
);
  logic [DIMENTION-1:0][WA-1:0] al, bl;
  logic [DIMENTION-1:0][WS-1:0] sl;

  assign al = a;
  assign bl = b;
  assign s  = sl;

  for (genvar k = 0; k < DIMENTION; k++) begin : g_lane
    residual_add_lane #(.WA(WA), .WS(WS)) u_lane (
      .a(al[k]), .b(bl[k]), .s(sl[k])
    );
  end
endmodule

module residual_add_scheduler #(
  parameter int ADDER_NUM    = 128,
  parameter int DIMENTION    = 768,
  parameter int WIDTH_ADDEND = 32,
  parameter int WIDTH_SUM    = WIDTH_ADDEND,
  parameter int ROW_AW       = $clog2(ADDER_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ROW_AW:0]                row_count,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [ROW_AW-1:0]              rd_addr,
  input  logic [WIDTH_ADDEND*DIMENTION-1:0] rd_data1,
  input  logic [WIDTH_ADDEND*DIMENTION-1:0] rd_data2,
  output logic                           wr_en,
  output logic [ROW_AW-1:0]              wr_addr,
  output logic [WIDTH_SUM*DIMENTION-1:0] wr_data,
  input  logic                           wr_ready
);
  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

  localparam logic [ROW_AW:0] NMAX = (ROW_AW+1)'(ADDER_NUM);
  localparam logic [ROW_AW:0] ONE  = (ROW_AW+1)'(1);

  state_t                        state, state_n;
  logic [ROW_AW:0]               n;
  logic [ROW_AW-1:0]             r;
  logic [WIDTH_SUM*DIMENTION-1:0] sum;
  logic                          last;
  logic                          in_job;

  adder_768 #(.DIMENTION(DIMENTION), .WA(WIDTH_ADDEND), .WS(WIDTH_SUM)) u_add (
    .a(rd_data1), .b(rd_data2), .s(sum)
  );

  assign last    = ({1'b0, r} == (n - ONE));
  assign in_job  = (state == READ) || (state == LATCH) || (state == WRITE);
  assign busy    = in_job;
  assign done    = (state == DONE);
  assign rd_en   = (state == READ);
  assign wr_en   = (state == WRITE);
  assign rd_addr = r;
  assign wr_addr = r;

  // Next-state: abort overrides every in-job transition.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = (row_count == '0) ? DONE : READ;
      READ:  state_n = LATCH;
      LATCH: state_n = WRITE;
      WRITE: if (wr_ready) state_n = last ? DONE : READ;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && in_job) state_n = IDLE;
  end

  // State, job length, row counter and the registered sum row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      r       <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        n <= (row_count > NMAX) ? NMAX : row_count;
        r <= '0;
      end
      if (state == LATCH) wr_data <= sum;
      if (state == WRITE && wr_ready && !last && !abort) r <= r + 1'b1;
    end
  end
endmodule
